// File: rtl/riscv_mem_stage.sv
// riscv_mem_stage: RV32 memory stage -- data-bus request/ack handshake with ack timeout and MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of masking the low offset bits.
module riscv_mem_stage #(
  parameter int XLEN          = 32,
  parameter int P_ACK_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid_m,
  input  logic            i_reg_write_m,
  input  logic [1:0]      i_result_src_m,
  input  logic            i_mem_write_m,
  input  logic [XLEN-1:0] i_alu_result_m,
  input  logic [XLEN-1:0] i_write_data_m,
  input  logic [4:0]      i_rd_m,
  input  logic [XLEN-1:0] i_pc_plus_4m,
  input  logic [2:0]      i_funct3_m,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stall_m,
  output logic            o_reg_write_w,
  output logic [1:0]      o_result_src_w,
  output logic [XLEN-1:0] o_read_data_w,
  output logic [XLEN-1:0] o_alu_result_w,
  output logic [4:0]      o_rd_w,
  output logic [XLEN-1:0] o_pc_plus_4w,
  output logic            o_bus_err_w,
  output logic            o_misalign_w
);

  localparam logic [7:0] LP_TIMEOUT = 8'(P_ACK_TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t r_state, w_state_nxt;

  logic            r_active;
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_addr, r_wdata, r_alu, r_pc4;
  logic [3:0]      r_be;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off, r_result_src;
  logic            r_we, r_reg_write;
  logic [4:0]      r_rd;

  logic            w_is_load, w_is_store, w_misalign, w_new_req, w_timeout;
  logic [1:0]      w_off;
  logic [3:0]      w_st_be;
  logic [XLEN-1:0] w_st_wdata, w_addr;

  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ld_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [XLEN-1:0] d);
    logic [XLEN-1:0] s;
    s = d >> {off, 3'b000};
    case (f3)
      3'b000:  return {{(XLEN-8){s[7]}}, s[7:0]};
      3'b001:  return {{(XLEN-16){s[15]}}, s[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, s[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, s[15:0]};
      default: return d;
    endcase
  endfunction

  assign w_is_load  = i_valid_m && (i_result_src_m == 2'b01);
  assign w_is_store = i_valid_m && i_mem_write_m;
  assign w_addr     = {i_alu_result_m[XLEN-1:2], 2'b00};
  assign w_off      = eff_off(i_funct3_m, i_alu_result_m[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = (w_is_load || w_is_store) &&
                      (((i_funct3_m[1:0] == 2'b01) && i_alu_result_m[0]) ||
                       ((i_funct3_m[1:0] == 2'b10) && (i_alu_result_m[1:0] != 2'b00)));
`else
  assign w_misalign   = 1'b0;
  assign o_misalign_w = 1'b0;
`endif

  // r_active keeps the combinational request path quiet from reset assertion until the first edge after release.
  assign w_new_req = r_active && (w_is_load || w_is_store) && !w_misalign;
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == LP_TIMEOUT);

  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = i_write_data_m;
    case (i_funct3_m[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << w_off;
        w_st_wdata = {4{i_write_data_m[7:0]}};
      end
      2'b01: begin
        w_st_be    = 4'b0011 << w_off;
        w_st_wdata = {2{i_write_data_m[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_active <= 1'b0;
      r_state  <= S_IDLE;
    end else begin
      r_active <= 1'b1;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_new_req && !i_dmem_ack) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_timeout || i_dmem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    o_dmem_be    = '0;
    o_stall_m    = 1'b0;
    case (r_state)
      S_IDLE: if (w_new_req) begin
        o_dmem_req   = 1'b1;
        o_dmem_we    = w_is_store;
        o_dmem_addr  = w_addr;
        o_dmem_wdata = w_is_store ? w_st_wdata : '0;
        o_dmem_be    = w_is_store ? w_st_be : 4'b1111;
        o_stall_m    = !i_dmem_ack;
      end
      S_WAIT: if (!w_timeout) begin
        o_dmem_req   = 1'b1;
        o_dmem_we    = r_we;
        o_dmem_addr  = r_addr;
        o_dmem_wdata = r_wdata;
        o_dmem_be    = r_be;
        o_stall_m    = !i_dmem_ack;
      end
      default: ;
    endcase
  end

  // Access fields are snapshotted every IDLE cycle; only the one leading into WAIT matters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_reg_write  <= 1'b0;
      r_result_src <= '0;
      r_rd         <= '0;
      r_alu        <= '0;
      r_pc4        <= '0;
    end else begin
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 8'd1 : '0;
      if (r_state == S_IDLE) begin
        r_addr       <= w_addr;
        r_wdata      <= w_is_store ? w_st_wdata : '0;
        r_be         <= w_is_store ? w_st_be : 4'b1111;
        r_we         <= w_is_store;
        r_funct3     <= i_funct3_m;
        r_off        <= w_off;
        r_reg_write  <= i_reg_write_m;
        r_result_src <= i_result_src_m;
        r_rd         <= i_rd_m;
        r_alu        <= i_alu_result_m;
        r_pc4        <= i_pc_plus_4m;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_reg_write_w  <= 1'b0;
      o_result_src_w <= '0;
      o_read_data_w  <= '0;
      o_alu_result_w <= '0;
      o_rd_w         <= '0;
      o_pc_plus_4w   <= '0;
      o_bus_err_w    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      o_misalign_w   <= 1'b0;
`endif
    end else if (o_stall_m) begin
      o_reg_write_w <= 1'b0;
      o_bus_err_w   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      o_misalign_w  <= 1'b0;
`endif
    end else if (r_state == S_WAIT) begin
      o_result_src_w <= r_result_src;
      o_alu_result_w <= r_alu;
      o_rd_w         <= r_rd;
      o_pc_plus_4w   <= r_pc4;
      o_reg_write_w  <= w_timeout ? 1'b0 : r_reg_write;
      o_bus_err_w    <= w_timeout;
`ifdef MISALIGN_TRAP_EN
      o_misalign_w   <= 1'b0;
`endif
      if (!w_timeout && !r_we) o_read_data_w <= ld_ext(r_funct3, r_off, i_dmem_rdata);
    end else begin
      o_result_src_w <= i_result_src_m;
      o_alu_result_w <= i_alu_result_m;
      o_rd_w         <= i_rd_m;
      o_pc_plus_4w   <= i_pc_plus_4m;
      o_reg_write_w  <= r_active && i_valid_m && i_reg_write_m && !w_misalign;
      o_bus_err_w    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      o_misalign_w   <= w_misalign;
`endif
      if (w_new_req && w_is_load && !w_is_store && i_dmem_ack)
        o_read_data_w <= ld_ext(i_funct3_m, w_off, i_dmem_rdata);
    end
  end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Directed self-checking bench for riscv_mem_stage (ack timeout shortened to 4 cycles).
module tb_riscv_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_valid_m, i_reg_write_m, i_mem_write_m;
  logic [1:0]  i_result_src_m;
  logic [31:0] i_alu_result_m, i_write_data_m, i_pc_plus_4m;
  logic [4:0]  i_rd_m;
  logic [2:0]  i_funct3_m;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_stall_m, o_reg_write_w, o_bus_err_w, o_misalign_w;
  logic [1:0]  o_result_src_w;
  logic [31:0] o_read_data_w, o_alu_result_w, o_pc_plus_4w;
  logic [4:0]  o_rd_w;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cnt;

  riscv_mem_stage #(.XLEN(32), .P_ACK_TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_valid_m(i_valid_m), .i_reg_write_m(i_reg_write_m), .i_result_src_m(i_result_src_m),
    .i_mem_write_m(i_mem_write_m), .i_alu_result_m(i_alu_result_m), .i_write_data_m(i_write_data_m),
    .i_rd_m(i_rd_m), .i_pc_plus_4m(i_pc_plus_4m), .i_funct3_m(i_funct3_m),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_stall_m(o_stall_m),
    .o_reg_write_w(o_reg_write_w), .o_result_src_w(o_result_src_w), .o_read_data_w(o_read_data_w),
    .o_alu_result_w(o_alu_result_w), .o_rd_w(o_rd_w), .o_pc_plus_4w(o_pc_plus_4w),
    .o_bus_err_w(o_bus_err_w), .o_misalign_w(o_misalign_w)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [2:0] f3);
    i_valid_m      = v;
    i_reg_write_m  = rw;
    i_result_src_m = rs;
    i_mem_write_m  = mw;
    i_alu_result_m = alu;
    i_write_data_m = wd;
    i_rd_m         = rd;
    i_pc_plus_4m   = alu + 32'h1000;
    i_funct3_m     = f3;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 3'b000);
    i_dmem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rstn       = 1'b0;
    i_dmem_rdata = 32'h0;
    idle_in();
    tick();
    tick();
    chk("rst_req", {31'b0, o_dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, o_stall_m}, 32'd0);
    chk("rst_be", {28'b0, o_dmem_be}, 32'd0);
    chk("rst_regwr", {31'b0, o_reg_write_w}, 32'd0);
    chk("rst_rdata", o_read_data_w, 32'h0);
    chk("rst_rd", {27'b0, o_rd_w}, 32'd0);
    i_rstn = 1'b1;
    tick();
    tick();

    // sw 0x100, ack in the request cycle
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h100, 32'hDEADBEEF, 5'd0, 3'b010);
    i_dmem_ack = 1'b1;
    #2;
    chk("sw_req", {31'b0, o_dmem_req}, 32'd1);
    chk("sw_we", {31'b0, o_dmem_we}, 32'd1);
    chk("sw_addr", o_dmem_addr, 32'h100);
    chk("sw_be", {28'b0, o_dmem_be}, 32'hF);
    chk("sw_wdata", o_dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall", {31'b0, o_stall_m}, 32'd0);
    tick();
    idle_in();
    #2;
    chk("sw_stall_after", {31'b0, o_stall_m}, 32'd0);
    chk("sw_wb_regwr", {31'b0, o_reg_write_w}, 32'd0);
    chk("sw_wb_alu", o_alu_result_w, 32'h100);
    tick();

    // ALU op with a stray ack: no request, latency-1 passthrough, read data untouched
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h12345678, 32'h0, 5'd5, 3'b000);
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hCAFEBABE;
    #2;
    chk("alu_req", {31'b0, o_dmem_req}, 32'd0);
    chk("alu_stall", {31'b0, o_stall_m}, 32'd0);
    tick();
    idle_in();
    chk("alu_wb_regwr", {31'b0, o_reg_write_w}, 32'd1);
    chk("alu_wb_alu", o_alu_result_w, 32'h12345678);
    chk("alu_wb_rd", {27'b0, o_rd_w}, 32'd5);
    chk("alu_wb_pc4", o_pc_plus_4w, 32'h12346678);
    chk("alu_wb_rdata", o_read_data_w, 32'h0);

    // sh 0x102
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0000BEEF, 5'd0, 3'b001);
    i_dmem_ack = 1'b1;
    #2;
    chk("sh_be", {28'b0, o_dmem_be}, 32'hC);
    chk("sh_wdata", o_dmem_wdata, 32'hBEEFBEEF);
    tick();
    idle_in();

    // sb 0x103, ack on the fourth request cycle; upstream fields scrambled while waiting
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h000000A5, 5'd0, 3'b000);
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) i_dmem_ack = 1'b1;
      #2;
      chk("sb_req", {31'b0, o_dmem_req}, 32'd1);
      chk("sb_addr", o_dmem_addr, 32'h100);
      chk("sb_be", {28'b0, o_dmem_be}, 32'h8);
      chk("sb_wdata", o_dmem_wdata, 32'hA5A5A5A5);
      stall_cnt += int'(o_stall_m);
      tick();
      if (c == 0) begin
        i_alu_result_m = 32'h200;
        i_write_data_m = 32'h0;
        i_funct3_m     = 3'b010;
      end
    end
    idle_in();
    chk("sb_stall_cycles", stall_cnt, 32'd3);
    chk("sb_wb_regwr", {31'b0, o_reg_write_w}, 32'd0);

    // lb 0x102, ack same cycle
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 5'd7, 3'b000);
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h12F04455;
    #2;
    chk("lb_we", {31'b0, o_dmem_we}, 32'd0);
    chk("lb_be", {28'b0, o_dmem_be}, 32'hF);
    chk("lb_addr", o_dmem_addr, 32'h100);
    tick();
    chk("lb_data", o_read_data_w, 32'hFFFFFFF0);
    chk("lb_regwr", {31'b0, o_reg_write_w}, 32'd1);
    chk("lb_rd", {27'b0, o_rd_w}, 32'd7);

    // lbu 0x102, ack after one wait cycle
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 5'd8, 3'b100);
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'h0;
    #2;
    chk("lbu_stall", {31'b0, o_stall_m}, 32'd1);
    tick();
    chk("lbu_bubble", {31'b0, o_reg_write_w}, 32'd0);
    i_funct3_m   = 3'b010;
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h12F04455;
    #2;
    chk("lbu_stall_ack", {31'b0, o_stall_m}, 32'd0);
    tick();
    chk("lbu_data", o_read_data_w, 32'h000000F0);
    chk("lbu_rd", {27'b0, o_rd_w}, 32'd8);

    // lhu 0x102
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 5'd9, 3'b101);
    i_dmem_ack = 1'b1;
    tick();
    chk("lhu_data", o_read_data_w, 32'h000012F0);
    chk("lhu_regwr", {31'b0, o_reg_write_w}, 32'd1);

    // lw with no ack: 1 request cycle + 4 WAIT cycles, then abort
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h200, 32'h0, 5'd10, 3'b010);
    i_dmem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("to_req", {31'b0, o_dmem_req}, 32'd1);
      chk("to_stall", {31'b0, o_stall_m}, 32'd1);
      tick();
      if (c == 0) chk("to_bubble", {31'b0, o_reg_write_w}, 32'd0);
    end
    #2;
    chk("to_req_drop", {31'b0, o_dmem_req}, 32'd0);
    chk("to_stall_drop", {31'b0, o_stall_m}, 32'd0);
    tick();
    idle_in();
    chk("to_bus_err", {31'b0, o_bus_err_w}, 32'd1);
    chk("to_regwr", {31'b0, o_reg_write_w}, 32'd0);
    chk("to_rd", {27'b0, o_rd_w}, 32'd10);
    tick();
    chk("to_bus_err_clr", {31'b0, o_bus_err_w}, 32'd0);

    // reset pulse while waiting
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h300, 32'h0, 5'd3, 3'b010);
    #2;
    chk("rw_stall", {31'b0, o_stall_m}, 32'd1);
    tick();
    #2;
    chk("rw_req_wait", {31'b0, o_dmem_req}, 32'd1);
    i_rstn = 1'b0;
    #1;
    chk("rw_req_async", {31'b0, o_dmem_req}, 32'd0);
    chk("rw_stall_async", {31'b0, o_stall_m}, 32'd0);
    chk("rw_wb_cleared", o_alu_result_w, 32'h0);
    idle_in();
    #2;
    i_rstn = 1'b1;
    tick();
    tick();
    chk("rw_regwr", {31'b0, o_reg_write_w}, 32'd0);
    chk("rw_req_idle", {31'b0, o_dmem_req}, 32'd0);

    // lw 0x101
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 5'd4, 3'b010);
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hA1B2C3D4;
    #2;
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", {31'b0, o_dmem_req}, 32'd0);
    chk("mis_stall", {31'b0, o_stall_m}, 32'd0);
    tick();
    chk("mis_flag", {31'b0, o_misalign_w}, 32'd1);
    chk("mis_regwr", {31'b0, o_reg_write_w}, 32'd0);
`else
    chk("mis_req", {31'b0, o_dmem_req}, 32'd1);
    chk("mis_addr", o_dmem_addr, 32'h100);
    tick();
    chk("mis_flag", {31'b0, o_misalign_w}, 32'd0);
    chk("mis_data", o_read_data_w, 32'hA1B2C3D4);
    chk("mis_regwr", {31'b0, o_reg_write_w}, 32'd1);
`endif
    idle_in();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
